axis_crc24_check: RTL and testbench

Receive-side CRC-24 checker for the byte-wide AXI-Stream CRC path. It consumes frames of payload bytes followed by three appended CRC-24 bytes (polynomial 0x1864CFB, MSB-first, init 0, no final XOR). It strips the CRC and forwards the payload downstream with `m_tlast` on the final payload byte. It reports a per-frame pass/fail strobe and saturating frame and error counters.

---
 rtl/crc24_pkg.sv | 27 ++
 rtl/crc24_holdback.sv | 88 ++++++++
 rtl/axis_crc24_check.sv | 101 ++++++++++
 tb/tb_axis_crc24_check.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc24_pkg.sv
// Shared constants and the byte-wide CRC-24 step used by the receive-side checker.
// The polynomial is given without the implicit x^24 term.
package crc24_pkg;

    localparam logic [23:0] CRC24_POLY = 24'h864CFB;
    localparam logic [23:0] CRC24_INIT = 24'h000000;

    typedef logic [1:0] fill_t;

    // Holdback depth equals the CRC length in bytes; at this fill the buffer streams.
    localparam fill_t FILL_FULL = 2'd3;

    // MSB-first: the data byte enters at the top of the register, one bit per iteration.
    function automatic logic [23:0] crc24_byte(
        input logic [23:0] crc,
        input logic [7:0]  data,
        input logic [23:0] poly = CRC24_POLY
    );
        logic [23:0] c;
        c = crc ^ {data, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            c = c[23] ? ({c[22:0], 1'b0} ^ poly) : {c[22:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc24_holdback.sv
// Three-byte delay line that hides the trailing CRC bytes, plus the registered
// AXI-Stream output stage. fill_o is the FILL/STREAM state (STREAM when full).
module crc24_holdback
    import crc24_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_tdata_i,
    input  logic       s_tvalid_i,
    input  logic       s_tlast_i,
    output logic       s_tready_o,
    output logic [7:0] m_tdata_o,
    output logic       m_tvalid_o,
    output logic       m_tlast_o,
    input  logic       m_tready_i,
    output logic       acc_o,
    output fill_t      fill_o
);

    logic [2:0][7:0] hold_q, hold_d;
    fill_t           fill_q, fill_d;
    logic [7:0]      m_tdata_q, m_tdata_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            m_tlast_q, m_tlast_d;
    logic            acc;
    logic            streaming;

    // Handshake: a byte is accepted when s_tvalid & s_tready; the input is only
    // stalled while the output register holds a beat the sink is refusing.
    assign s_tready_o = !m_tvalid_q || m_tready_i;
    assign acc        = s_tvalid_i && s_tready_o;
    assign streaming  = (fill_q == FILL_FULL);

    always_comb begin
        hold_d     = hold_q;
        fill_d     = fill_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;

        if (m_tvalid_q && m_tready_i) begin
            m_tvalid_d = 1'b0;
        end

        if (acc) begin
            if (streaming) begin
                m_tdata_d  = hold_q[0];
                m_tvalid_d = 1'b1;
                m_tlast_d  = s_tlast_i;
                hold_d     = {s_tdata_i, hold_q[2], hold_q[1]};
            end else begin
                case (fill_q)
                    2'd0:    hold_d[0] = s_tdata_i;
                    2'd1:    hold_d[1] = s_tdata_i;
                    default: hold_d[2] = s_tdata_i;
                endcase
                fill_d = fill_q + 2'd1;
            end
            // At frame end the held bytes are CRC (or a runt) and are dropped.
            if (s_tlast_i) begin
                fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q     <= '0;
            fill_q     <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            fill_q     <= fill_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign m_tdata_o  = m_tdata_q;
    assign m_tvalid_o = m_tvalid_q;
    assign m_tlast_o  = m_tlast_q;
    assign acc_o      = acc;
    assign fill_o     = fill_q;

endmodule

// File: rtl/axis_crc24_check.sv
// Receive-side CRC-24 checker: strips the three trailing CRC bytes, forwards the
// payload, and reports a per-frame verdict with saturating frame/error counters.
module axis_crc24_check
    import crc24_pkg::*;
#(
    parameter logic [23:0] POLY  = CRC24_POLY,
    parameter logic [23:0] INIT  = CRC24_INIT,
    parameter int          CNT_W = 16
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             chk_valid,
    output logic             chk_ok,
    output logic             runt_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic             acc;
    fill_t            fill;
    logic [23:0]      crc_q, crc_d, crc_next;
    logic             frame_end, runt, frame_ok;
    logic             chk_valid_q, chk_valid_d;
    logic             chk_ok_q, chk_ok_d;
    logic             runt_err_q, runt_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    crc24_holdback u_holdback (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tdata_i  (s_tdata),
        .s_tvalid_i (s_tvalid),
        .s_tlast_i  (s_tlast),
        .s_tready_o (s_tready),
        .m_tdata_o  (m_tdata),
        .m_tvalid_o (m_tvalid),
        .m_tlast_o  (m_tlast),
        .m_tready_i (m_tready),
        .acc_o      (acc),
        .fill_o     (fill)
    );

    // Running the CRC over payload and appended CRC leaves a zero residue on a good frame.
    assign crc_next  = crc24_byte(crc_q, s_tdata, POLY);
    assign frame_end = acc && s_tlast;
    assign runt      = frame_end && (fill != FILL_FULL);
    assign frame_ok  = (crc_next == 24'h000000) && !runt;

    always_comb begin
        crc_d       = crc_q;
        chk_valid_d = frame_end;
        chk_ok_d    = frame_end && frame_ok;
        runt_err_d  = runt;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (acc) begin
            crc_d = frame_end ? INIT : crc_next;
        end
        if (frame_end && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (frame_end && !frame_ok && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q       <= INIT;
            chk_valid_q <= 1'b0;
            chk_ok_q    <= 1'b0;
            runt_err_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            crc_q       <= crc_d;
            chk_valid_q <= chk_valid_d;
            chk_ok_q    <= chk_ok_d;
            runt_err_q  <= runt_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign chk_valid = chk_valid_q;
    assign chk_ok    = chk_ok_q;
    assign runt_err  = runt_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axis_crc24_check.sv
// Scoreboard bench for axis_crc24_check: a long-division CRC model predicts the
// payload beats and frame verdicts; a negedge monitor pops and compares them.
module tb_axis_crc24_check;

    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef logic [7:0] bq_t[$];

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic             s_tlast;
    logic [7:0]       m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic             chk_valid;
    logic             chk_ok;
    logic             runt_err;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];   // {tlast, data}
    logic [1:0] chk_q[$];   // {runt, ok}
    int         exp_frames = 0;
    int         exp_errs   = 0;
    logic       rand_ready = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat  = '0;

    always #5 clk = ~clk;

    axis_crc24_check #(
        .POLY  (24'h864CFB),
        .INIT  (24'h000000),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .chk_valid (chk_valid),
        .chk_ok    (chk_ok),
        .runt_err  (runt_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Remainder of (message * x^24) modulo x^24+POLY by plain polynomial long division.
    function automatic logic [23:0] model_rem(input bq_t msg);
        logic [24:0] r;
        logic        b;
        int          n;
        r = '0;
        n = msg.size();
        for (int i = 0; i < n * 8 + 24; i++) begin
            b = (i < n * 8) ? msg[i / 8][7 - (i % 8)] : 1'b0;
            r = {r[23:0], b};
            if (r[24]) r = r ^ 25'h1864CFB;
        end
        return r[23:0];
    endfunction

    function automatic bq_t make_frame(input int plen, input bit corrupt);
        bq_t         f;
        logic [23:0] c;
        int          k;
        for (int i = 0; i < plen; i++) f.push_back(8'($urandom));
        c = model_rem(f);
        f.push_back(c[23:16]);
        f.push_back(c[15:8]);
        f.push_back(c[7:0]);
        if (corrupt) begin
            k = $urandom_range(0, f.size() - 1);
            f[k] = f[k] ^ (8'h01 << $urandom_range(0, 7));
        end
        return f;
    endfunction

    // Starts and ends just after a rising edge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        forever begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL s_tready_timeout actual=0 required=1");
                @(posedge clk);
                #1;
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_frame(input bq_t f);
        int   n;
        logic ok;
        n = f.size();
        if (n < 4) begin
            chk_q.push_back(2'b10);
            ok = 1'b0;
        end else begin
            for (int k = 0; k < n - 3; k++) exp_q.push_back({(k == n - 4), f[k]});
            ok = (model_rem(f) == 24'h000000);
            chk_q.push_back({1'b0, ok});
        end
        if (exp_frames < CMAX) exp_frames++;
        if (!ok && exp_errs < CMAX) exp_errs++;
        for (int k = 0; k < n; k++) send_byte(f[k], (k == n - 1));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        rand_ready = 1'b0;
        while ((exp_q.size() != 0 || chk_q.size() != 0) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_pending"}, 32'(exp_q.size() + chk_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_errs));
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: everything is sampled at the falling edge, ahead of the edge that acts on it.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", 32'(m_tvalid), 32'd1);
                    check("stall_hold_beat", 32'({m_tlast, m_tdata}), 32'(prev_beat));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none", {m_tlast, m_tdata});
                    end else begin
                        check("beat", 32'({m_tlast, m_tdata}), 32'(exp_q.pop_front()));
                    end
                end
                if (chk_valid) begin
                    if (chk_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_chk_valid actual=1 required=0");
                    end else begin
                        logic [1:0] e;
                        e = chk_q.pop_front();
                        check("chk_ok", 32'(chk_ok), 32'(e[0]));
                        check("runt_err", 32'(runt_err), 32'(e[1]));
                        if (!e[1]) check("chk_with_tlast", 32'({m_tvalid, m_tlast}), 32'd3);
                    end
                end else if (runt_err) begin
                    checks++;
                    errors++;
                    $display("FAIL runt_without_chk actual=1 required=0");
                end
                prev_stall = m_tvalid && !m_tready;
                prev_beat  = {m_tlast, m_tdata};
            end
        end
    end

    initial begin
        bq_t f;
        reset_n  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        check("rst_chk", 32'({chk_valid, chk_ok, runt_err}), 32'd0);
        check("rst_counters", 32'({frame_cnt, err_cnt}), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        f = '{8'h01, 8'h86, 8'h4C, 8'hFB};
        run_frame(f);
        drain("good_min");
        f = '{8'h01, 8'h86, 8'h4C, 8'hFA};
        run_frame(f);
        drain("bad_min");
        f = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(f);
        drain("zeros");
        f = '{8'hAA, 8'hBB};
        run_frame(f);
        drain("runt");

        // Two back-to-back good frames under random downstream backpressure.
        rand_ready = 1'b1;
        f = make_frame($urandom_range(1, 10), 1'b0);
        run_frame(f);
        f = make_frame($urandom_range(1, 10), 1'b0);
        run_frame(f);
        drain("b2b_backpressure");

        // Mixed good, corrupt and runt frames: enough to saturate both counters.
        for (int i = 0; i < 9; i++) begin
            rand_ready = 1'b1;
            if (i % 3 == 2) begin
                f.delete();
                for (int k = 0; k < $urandom_range(1, 3); k++) f.push_back(8'($urandom));
            end else begin
                f = make_frame($urandom_range(1, 12), (i % 3 == 1));
            end
            run_frame(f);
        end
        drain("saturate");

        // Reset after two bytes of a frame; partial state must vanish.
        send_byte(8'h01, 1'b0);
        send_byte(8'h86, 1'b0);
        reset_n = 1'b0;
        exp_frames = 0;
        exp_errs   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_counters", 32'({frame_cnt, err_cnt}), 32'd0);
        check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        f = '{8'h01, 8'h86, 8'h4C, 8'hFB};
        run_frame(f);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
